// File: rtl/fp_pkg.sv
// Shared floating-point types and helpers for the FPU datapath.
// Contents:
//   fp_class_e  - operand class after decode (subnormals decode as ZERO)
//   rnd_mode_e  - rounding mode encoding as presented on rnd_mode inputs
//   fp_flags_t  - per-result exception flags
//   bias()      - exponent bias for a given exponent field width
package fp_pkg;

    typedef enum logic [2:0] {
        ZERO,
        NORM,
        INF,
        QNAN,
        SNAN
    } fp_class_e;

    typedef enum logic {
        RNE = 1'b0,
        RTZ = 1'b1
    } rnd_mode_e;

    typedef struct packed {
        logic overflow;
        logic underflow;
        logic inexact;
        logic invalid;
    } fp_flags_t;

    function automatic int unsigned bias(input int unsigned exp_w);
        return (32'd1 << (exp_w - 1)) - 32'd1;
    endfunction

endpackage

// File: rtl/fp_round_pack.sv
// Combinational round / range-check / pack for the last stage of an FP pipeline.
// Ports:
//   sign_i          result sign
//   exp_i           signed, biased, already-normalised exponent (EXP_W+2 bits)
//   man_i           normalised significand including hidden bit (MAN_W+1 bits)
//   guard_i         first bit below man_i
//   sticky_i        OR of every bit below guard_i
//   rnd_mode_i      0 = round-to-nearest-even, 1 = round-toward-zero
//   special_i       bypass: special_res_i / special_flags_i are the result
//   special_res_i   packed special result {sign, exp, man}
//   special_flags_i flags belonging to the special result
//   res_o           packed result {sign, exp, man}
//   flags_o         overflow / underflow / inexact / invalid for res_o
module fp_round_pack
    import fp_pkg::*;
#(
    parameter int unsigned EXP_W = 8,
    parameter int unsigned MAN_W = 7
) (
    input  logic                    sign_i,
    input  logic signed [EXP_W+1:0] exp_i,
    input  logic [MAN_W:0]          man_i,
    input  logic                    guard_i,
    input  logic                    sticky_i,
    input  logic                    rnd_mode_i,
    input  logic                    special_i,
    input  logic [EXP_W+MAN_W:0]    special_res_i,
    input  fp_flags_t               special_flags_i,
    output logic [EXP_W+MAN_W:0]    res_o,
    output fp_flags_t               flags_o
);

    localparam logic signed [EXP_W+1:0] ExpZero = '0;
    localparam logic signed [EXP_W+1:0] ExpOne  = {{(EXP_W+1){1'b0}}, 1'b1};
    localparam logic signed [EXP_W+1:0] EmaxS   = {2'b00, {EXP_W{1'b1}}};

    logic                    round_up;
    logic [MAN_W+1:0]        man_sum;
    logic [MAN_W:0]          man_rnd;
    logic signed [EXP_W+1:0] exp_rnd;

    always_comb begin
        round_up = (rnd_mode_i == RNE) & guard_i & (sticky_i | man_i[0]);
        man_sum  = {1'b0, man_i} + {{(MAN_W+1){1'b0}}, round_up};
        // A carry out leaves 10..0, so dropping the LSB renormalises exactly.
        if (man_sum[MAN_W+1]) begin
            man_rnd = man_sum[MAN_W+1:1];
            exp_rnd = exp_i + ExpOne;
        end else begin
            man_rnd = man_sum[MAN_W:0];
            exp_rnd = exp_i;
        end

        res_o   = '0;
        flags_o = '0;
        if (special_i) begin
            res_o   = special_res_i;
            flags_o = special_flags_i;
        end else if (exp_i <= ExpZero) begin
            // Underflow is judged on the pre-rounding exponent; flush to zero.
            res_o             = {sign_i, {(EXP_W+MAN_W){1'b0}}};
            flags_o.underflow = 1'b1;
            flags_o.inexact   = 1'b1;
        end else if (exp_rnd >= EmaxS) begin
            flags_o.overflow = 1'b1;
            flags_o.inexact  = 1'b1;
            if (rnd_mode_i == RTZ) begin
                res_o = {sign_i, {(EXP_W-1){1'b1}}, 1'b0, {MAN_W{1'b1}}};
            end else begin
                res_o = {sign_i, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
            end
        end else begin
            res_o           = {sign_i, exp_rnd[EXP_W-1:0], man_rnd[MAN_W-1:0]};
            flags_o.inexact = guard_i | sticky_i;
        end
    end

endmodule

// File: rtl/fp_mul_pipe.sv
// 3-stage pipelined floating-point multiplier with valid/ready handshake.
//   S1: unpack, classify, special-case result, mantissa multiply
//   S2: exponent add, normalise, guard/sticky extraction
//   S3: round, range check, pack (fp_round_pack) into the output registers
// Subnormal inputs are treated as zero; results that underflow flush to zero.
// Ports:
//   clk, reset               clock, asynchronous active-low reset
//   in_valid / in_ready      operand handshake
//   opA, opB                 operands {sign, exp, man}
//   rnd_mode                 0 = RNE, 1 = RTZ, sampled with the operands
//   in_tag / out_tag         opaque tag returned with the result
//   out_valid / out_ready    result handshake
//   product                  result {sign, exp, man}
//   overflow, underflow,
//   inexact, invalid         per-result flags, held with product
module fp_mul_pipe
    import fp_pkg::*;
#(
    parameter int unsigned EXP_W = 8,
    parameter int unsigned MAN_W = 7,
    parameter int unsigned TAG_W = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [EXP_W+MAN_W:0]   opA,
    input  logic [EXP_W+MAN_W:0]   opB,
    input  logic                   rnd_mode,
    input  logic [TAG_W-1:0]       in_tag,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [EXP_W+MAN_W:0]   product,
    output logic [TAG_W-1:0]       out_tag,
    output logic                   overflow,
    output logic                   underflow,
    output logic                   inexact,
    output logic                   invalid
);

    localparam int unsigned W  = 1 + EXP_W + MAN_W;
    localparam int unsigned PW = 2 * MAN_W + 2;

    localparam logic signed [EXP_W+1:0] BiasS  = (EXP_W+2)'(bias(EXP_W));
    localparam logic signed [EXP_W+1:0] ExpOne = {{(EXP_W+1){1'b0}}, 1'b1};
    localparam logic [W-1:0]            QNaN   =
        {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

    typedef struct packed {
        logic             sign;
        logic             special;
        logic [W-1:0]     special_res;
        fp_flags_t        special_flags;
        logic [EXP_W-1:0] exp_a;
        logic [EXP_W-1:0] exp_b;
        logic [PW-1:0]    man_prod;
        logic             rnd;
        logic [TAG_W-1:0] tag;
    } s1_t;

    typedef struct packed {
        logic                    sign;
        logic                    special;
        logic [W-1:0]            special_res;
        fp_flags_t               special_flags;
        logic signed [EXP_W+1:0] exp;
        logic [MAN_W:0]          man;
        logic                    guard;
        logic                    sticky;
        logic                    rnd;
        logic [TAG_W-1:0]        tag;
    } s2_t;

    function automatic fp_class_e classify(input logic [EXP_W-1:0] e, input logic [MAN_W-1:0] m);
        if (e == '0) return ZERO;
        if (e == '1) return (m == '0) ? INF : (m[MAN_W-1] ? QNAN : SNAN);
        return NORM;
    endfunction

    // Handshake: each stage advances when empty or when its successor advances.
    logic adv1, adv2, adv3;
    logic v1_q, v2_q, out_valid_q;

    assign adv3     = !out_valid_q | out_ready;
    assign adv2     = !v2_q | adv3;
    assign adv1     = !v1_q | adv2;
    assign in_ready = adv1;

    // ---------------- Stage 1 ----------------
    s1_t           s1_d, s1_q;
    fp_class_e     cls_a, cls_b;
    logic [PW-1:0] sig_a, sig_b;
    logic          a_nan, b_nan;

    always_comb begin
        s1_d  = '0;
        cls_a = classify(opA[W-2:MAN_W], opA[MAN_W-1:0]);
        cls_b = classify(opB[W-2:MAN_W], opB[MAN_W-1:0]);
        a_nan = (cls_a == QNAN) || (cls_a == SNAN);
        b_nan = (cls_b == QNAN) || (cls_b == SNAN);
        sig_a = PW'({1'b1, opA[MAN_W-1:0]});
        sig_b = PW'({1'b1, opB[MAN_W-1:0]});

        s1_d.sign     = opA[W-1] ^ opB[W-1];
        s1_d.exp_a    = opA[W-2:MAN_W];
        s1_d.exp_b    = opB[W-2:MAN_W];
        s1_d.man_prod = sig_a * sig_b;
        s1_d.rnd      = rnd_mode;
        s1_d.tag      = in_tag;

        if (a_nan || b_nan) begin
            s1_d.special               = 1'b1;
            s1_d.special_res           = QNaN;
            s1_d.special_flags.invalid = (cls_a == SNAN) || (cls_b == SNAN);
        end else if ((cls_a == ZERO && cls_b == INF) || (cls_a == INF && cls_b == ZERO)) begin
            s1_d.special               = 1'b1;
            s1_d.special_res           = QNaN;
            s1_d.special_flags.invalid = 1'b1;
        end else if (cls_a == INF || cls_b == INF) begin
            s1_d.special     = 1'b1;
            s1_d.special_res = {s1_d.sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
        end else if (cls_a == ZERO || cls_b == ZERO) begin
            s1_d.special     = 1'b1;
            s1_d.special_res = {s1_d.sign, {(EXP_W+MAN_W){1'b0}}};
        end
    end

    // ---------------- Stage 2 ----------------
    s2_t                     s2_d, s2_q;
    logic signed [EXP_W+1:0] exp_sum;
    logic [PW-1:0]           norm;

    always_comb begin
        s2_d    = '0;
        exp_sum = $signed({2'b00, s1_q.exp_a}) + $signed({2'b00, s1_q.exp_b}) - BiasS;
        // Product of two [1,2) significands lies in [1,4); align so bit PW-1 is the leading one.
        if (s1_q.man_prod[PW-1]) begin
            norm     = s1_q.man_prod;
            s2_d.exp = exp_sum + ExpOne;
        end else begin
            norm     = s1_q.man_prod << 1;
            s2_d.exp = exp_sum;
        end
        s2_d.man           = norm[PW-1:MAN_W+1];
        s2_d.guard         = norm[MAN_W];
        s2_d.sticky        = |norm[MAN_W-1:0];
        s2_d.sign          = s1_q.sign;
        s2_d.special       = s1_q.special;
        s2_d.special_res   = s1_q.special_res;
        s2_d.special_flags = s1_q.special_flags;
        s2_d.rnd           = s1_q.rnd;
        s2_d.tag           = s1_q.tag;
    end

    // ---------------- Stage 3 ----------------
    logic [W-1:0] rp_res;
    fp_flags_t    rp_flags;

    fp_round_pack #(
        .EXP_W (EXP_W),
        .MAN_W (MAN_W)
    ) u_round_pack (
        .sign_i          (s2_q.sign),
        .exp_i           (s2_q.exp),
        .man_i           (s2_q.man),
        .guard_i         (s2_q.guard),
        .sticky_i        (s2_q.sticky),
        .rnd_mode_i      (s2_q.rnd),
        .special_i       (s2_q.special),
        .special_res_i   (s2_q.special_res),
        .special_flags_i (s2_q.special_flags),
        .res_o           (rp_res),
        .flags_o         (rp_flags)
    );

    logic [W-1:0]     res_q;
    logic [TAG_W-1:0] tag_q;
    fp_flags_t        flags_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            v1_q        <= 1'b0;
            v2_q        <= 1'b0;
            out_valid_q <= 1'b0;
            s1_q        <= '0;
            s2_q        <= '0;
            res_q       <= '0;
            tag_q       <= '0;
            flags_q     <= '0;
        end else begin
            if (adv1) begin
                v1_q <= in_valid;
                if (in_valid) s1_q <= s1_d;
            end
            if (adv2) begin
                v2_q <= v1_q;
                if (v1_q) s2_q <= s2_d;
            end
            if (adv3) begin
                out_valid_q <= v2_q;
                if (v2_q) begin
                    res_q   <= rp_res;
                    flags_q <= rp_flags;
                    tag_q   <= s2_q.tag;
                end
            end
        end
    end

    assign out_valid = out_valid_q;
    assign product   = res_q;
    assign out_tag   = tag_q;
    assign overflow  = flags_q.overflow;
    assign underflow = flags_q.underflow;
    assign inexact   = flags_q.inexact;
    assign invalid   = flags_q.invalid;

endmodule

// File: tb/tb_fp_mul_pipe.sv
// Scoreboard bench for fp_mul_pipe at bf16 defaults. Stimulus pushes expected results into a
// queue when an operand pair is accepted; an independent monitor pops and compares on every
// out_valid & out_ready handshake.
module tb_fp_mul_pipe;

    localparam int EXP_W = 8;
    localparam int MAN_W = 7;
    localparam int TAG_W = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] opA, opB;
    logic        rnd_mode;
    logic [3:0]  in_tag;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] product;
    logic [3:0]  out_tag;
    logic        overflow, underflow, inexact, invalid;

    fp_mul_pipe #(
        .EXP_W (EXP_W),
        .MAN_W (MAN_W),
        .TAG_W (TAG_W)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .opA       (opA),
        .opB       (opB),
        .rnd_mode  (rnd_mode),
        .in_tag    (in_tag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .product   (product),
        .out_tag   (out_tag),
        .overflow  (overflow),
        .underflow (underflow),
        .inexact   (inexact),
        .invalid   (invalid)
    );

    always #5 clk = ~clk;

    // flg = {overflow, underflow, inexact, invalid}
    typedef struct packed {
        logic [15:0] res;
        logic [3:0]  flg;
        logic [3:0]  tag;
    } exp_t;

    exp_t sb_q[$];
    int   errors = 0;
    int   checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Reference: exact integer significand product, rounded by comparing the discarded
    // remainder against one half ulp.
    function automatic exp_t model(input logic [15:0] a, input logic [15:0] b,
                                   input logic rm, input logic [3:0] tag);
        exp_t r;
        int   ea, eb, ma, mb, p, e, sh, q, rem, half;
        bit   sgn, an, bn, asn, bsn, ai, bi, az, bz;
        r     = '0;
        r.tag = tag;
        ea = int'(a[14:7]); ma = int'(a[6:0]);
        eb = int'(b[14:7]); mb = int'(b[6:0]);
        an  = (ea == 255) && (ma != 0);  bn  = (eb == 255) && (mb != 0);
        asn = an && !a[6];               bsn = bn && !b[6];
        ai  = (ea == 255) && (ma == 0);  bi  = (eb == 255) && (mb == 0);
        az  = (ea == 0);                 bz  = (eb == 0);
        sgn = a[15] ^ b[15];
        if (an || bn) begin
            r.res = 16'h7FC0; r.flg = {3'b000, asn || bsn}; return r;
        end
        if ((az && bi) || (ai && bz)) begin
            r.res = 16'h7FC0; r.flg = 4'b0001; return r;
        end
        if (ai || bi) begin
            r.res = {sgn, 8'hFF, 7'h00}; return r;
        end
        if (az || bz) begin
            r.res = {sgn, 15'h0000}; return r;
        end
        p  = (128 + ma) * (128 + mb);
        e  = ea + eb - 127;
        sh = 7;
        if (p >= 32768) begin e++; sh = 8; end
        q    = p >> sh;
        rem  = p % (1 << sh);
        half = 1 << (sh - 1);
        if (e <= 0) begin
            r.res = {sgn, 15'h0000}; r.flg = 4'b0110; return r;
        end
        if (!rm && (rem > half || (rem == half && (q % 2) == 1))) q++;
        if (q == 256) begin q = 128; e++; end
        if (e >= 255) begin
            r.res = rm ? {sgn, 8'hFE, 7'h7F} : {sgn, 8'hFF, 7'h00};
            r.flg = 4'b1010;
            return r;
        end
        r.res = {sgn, e[7:0], q[6:0]};
        r.flg = {2'b00, rem != 0, 1'b0};
        return r;
    endfunction

    function automatic logic [15:0] rand_op();
        logic [7:0] e;
        int         k;
        k = $urandom_range(0, 9);
        case (k)
            0:       e = 8'h00;
            1:       e = 8'hFF;
            2:       e = 8'($urandom_range(1, 20));
            3:       e = 8'($urandom_range(230, 254));
            default: e = 8'($urandom_range(100, 154));
        endcase
        return {1'($urandom_range(0, 1)), e, 7'($urandom)};
    endfunction

    // Present one operand pair and hold it until accepted; called at posedge+1.
    task automatic send(input logic [15:0] a, input logic [15:0] b, input logic rm,
                        input logic [3:0] tag, input exp_t e);
        int  waited = 0;
        bit  ok = 1'b0;
        in_valid = 1'b1; opA = a; opB = b; rnd_mode = rm; in_tag = tag;
        while (!ok) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1'b1;
            end else begin
                waited++;
                if (waited > 200) begin
                    errors++; checks++;
                    $display("FAIL accept_timeout: in_ready stuck at 0, required 1 (tag %0d)", tag);
                    break;
                end
                @(posedge clk); #1;
            end
        end
        if (ok) sb_q.push_back(e);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (sb_q.size() != 0 && n < 300) begin
            @(posedge clk); #1; n++;
        end
        chk("drain_pending", sb_q.size(), 0);
    endtask

    // ---------------- Monitor ----------------
    bit          held = 1'b0;
    logic [15:0] held_res;
    logic [3:0]  held_flg, held_tag;

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (!reset) begin
                held = 1'b0;
            end else begin
                if (held) begin
                    chk("hold_valid", out_valid, 1);
                    chk("hold_product", product, held_res);
                    chk("hold_flags", {overflow, underflow, inexact, invalid}, held_flg);
                    chk("hold_tag", out_tag, held_tag);
                end
                held = 1'b0;
                if (out_valid && out_ready) begin
                    if (sb_q.size() == 0) begin
                        errors++; checks++;
                        $display("FAIL unexpected_output: got product 0x%0h tag %0d, required none",
                                 product, out_tag);
                    end else begin
                        e = sb_q.pop_front();
                        chk("product", product, e.res);
                        chk("flags", {overflow, underflow, inexact, invalid}, e.flg);
                        chk("tag", out_tag, e.tag);
                    end
                end else if (out_valid) begin
                    held     = 1'b1;
                    held_res = product;
                    held_flg = {overflow, underflow, inexact, invalid};
                    held_tag = out_tag;
                end
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not complete, required completion");
        $fatal(1, "watchdog expired");
    end

    // Directed vectors with hand-derived results.
    localparam int ND = 12;
    logic [15:0] d_a   [ND] = '{16'h3FC0, 16'h3FC0, 16'h3FC0, 16'h3F81, 16'h7F00, 16'h7F00,
                                16'h0080, 16'h8080, 16'h0000, 16'h7F81, 16'h7FC1, 16'hFF80};
    logic [15:0] d_b   [ND] = '{16'h3FC0, 16'h3F81, 16'h3F81, 16'h3F81, 16'h4000, 16'h4000,
                                16'h3F00, 16'h3F00, 16'h7F80, 16'h3F80, 16'h3F80, 16'h4000};
    logic        d_rm  [ND] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1,
                                1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    logic [15:0] d_res [ND] = '{16'h4010, 16'h3FC2, 16'h3FC1, 16'h3F82, 16'h7F80, 16'h7F7F,
                                16'h0000, 16'h8000, 16'h7FC0, 16'h7FC0, 16'h7FC0, 16'hFF80};
    logic [3:0]  d_flg [ND] = '{4'b0000, 4'b0010, 4'b0010, 4'b0010, 4'b1010, 4'b1010,
                                4'b0110, 4'b0110, 4'b0001, 4'b0001, 4'b0000, 4'b0000};

    bit drv_done;

    initial begin : main
        int          n;
        int          seen;
        logic [15:0] a, b;
        logic        rm;
        exp_t        e;

        reset = 1'b0; in_valid = 1'b0; opA = '0; opB = '0; rnd_mode = 1'b0; in_tag = '0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_out_valid", out_valid, 0);
        chk("reset_product", product, 0);
        chk("reset_flags", {overflow, underflow, inexact, invalid}, 0);
        chk("reset_tag", out_tag, 0);
        reset = 1'b1;
        @(posedge clk); #1;
        chk("ready_after_reset", in_ready, 1);

        // Latency: the accept edge loads S1, the next two edges S2 and the output stage, so
        // out_valid is visible two edges after the accept edge (third cycle after acceptance).
        e.res = d_res[0]; e.flg = d_flg[0]; e.tag = 4'd0;
        send(d_a[0], d_b[0], d_rm[0], 4'd0, e);
        n = 0;
        while (!out_valid && n < 10) begin
            @(posedge clk); #1; n++;
        end
        chk("latency_edges", n, 2);
        drain();

        for (int i = 1; i < ND; i++) begin
            e.res = d_res[i]; e.flg = d_flg[i]; e.tag = 4'(i);
            send(d_a[i], d_b[i], d_rm[i], 4'(i), e);
        end
        drain();

        // Back-pressure: 6 streamed ops, output stalled for 5 cycles after the first result.
        fork
            begin
                for (int i = 0; i < 6; i++) begin
                    a = rand_op(); b = rand_op(); rm = 1'($urandom_range(0, 1));
                    send(a, b, rm, 4'(8 + i), model(a, b, rm, 4'(8 + i)));
                end
            end
            begin
                n = 0;
                do begin
                    @(negedge clk); n++;
                end while (!out_valid && n < 50);
                @(posedge clk); #1;
                out_ready = 1'b0;
                repeat (5) begin
                    @(negedge clk);
                    chk("bp_in_ready_low", in_ready, 0);
                    chk("bp_out_valid", out_valid, 1);
                    @(posedge clk); #1;
                end
                out_ready = 1'b1;
            end
        join
        drain();

        // Randomised traffic with random gaps and random back-pressure.
        drv_done = 1'b0;
        fork
            begin
                for (int i = 0; i < 400; i++) begin
                    a = rand_op(); b = rand_op(); rm = 1'($urandom_range(0, 1));
                    send(a, b, rm, 4'(i), model(a, b, rm, 4'(i)));
                    repeat ($urandom_range(0, 3) == 0 ? $urandom_range(1, 2) : 0) begin
                        @(posedge clk); #1;
                    end
                end
                drv_done = 1'b1;
            end
            begin
                while (!drv_done) begin
                    out_ready = ($urandom_range(0, 3) != 0);
                    @(posedge clk); #1;
                end
                out_ready = 1'b1;
            end
        join
        drain();

        // Reset mid-stream: fill the pipeline with the output stalled, then reset.
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            a = rand_op(); b = rand_op();
            send(a, b, 1'b0, 4'(i), model(a, b, 1'b0, 4'(i)));
        end
        chk("pre_reset_out_valid", out_valid, 1);
        #2;
        reset = 1'b0;
        sb_q.delete();
        #1;
        chk("reset_clears_out_valid", out_valid, 0);
        repeat (2) @(posedge clk);
        #3;
        reset = 1'b1;
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk("ready_after_midreset", in_ready, 1);
        seen = 0;
        repeat (10) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        chk("no_emit_after_reset", seen, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fp_mul_pipe.md
# fp_mul_pipe

Parametrised, 3-stage pipelined IEEE-style floating-point multiplier for the FPU datapath. It generalises the combinational bfloat16 multiplier to any exponent and mantissa width. It adds correct rounding (RNE/RTZ), IEEE special-value handling, flush-to-zero underflow and a valid/ready handshake with full back-pressure. It sits between the FPU operand issue logic and the result writeback arbiter.

## Interface
- EXP_W, 8, exponent field width (≥3)
- MAN_W, 7, stored mantissa width, hidden bit excluded (≥2)
- TAG_W, 4, width of opaque tag carried alongside each operation
- clk  in  1  clock; all state updates on its rising edge
- reset  in  1  asynchronous, active-low reset
- in_valid  in  1  operand pair present
- in_ready  out  1  stage 1 can accept this cycle
- opA, opB  in  1+EXP_W+MAN_W  operands {sign, exp, man}
- rnd_mode  in  1  0 = round-to-nearest-even, 1 = round-toward-zero; sampled with operands
- in_tag  in  TAG_W  returned unchanged with the result
- out_valid  out  1  result present
- out_ready  in  1  consumer accepts the result
- product  out  1+EXP_W+MAN_W  result
- out_tag  out  TAG_W  tag of the result
- overflow, underflow, inexact, invalid  out  1 each  sticky-free, per-result flags

## Operation
- BIAS = 2^(EXP_W-1)-1. EMAX_FIELD = 2^EXP_W-1.
- Classification: exp==0 is zero, and subnormal inputs are treated as zero (DAZ). exp==EMAX_FIELD with man==0 is Inf. exp==EMAX_FIELD with man≠0 is NaN. A NaN is signalling when man MSB==0.
- Sign is always sA^sB, except for NaN results.
- Special cases, in priority order:
  - Any NaN input gives the canonical qNaN {0, all-ones, 1, 0…}. invalid=1 iff any input NaN is signalling.
  - 0×Inf gives qNaN with invalid=1.
  - Inf×x gives signed Inf with no flags.
  - 0×x gives signed zero with no flags.
- Normal path:
  - Mantissa product is (MAN_W+1)×(MAN_W+1) = 2·MAN_W+2 bits.
  - Exponent is signed, EXP_W+2 bits: e = eA+eB−BIAS.
  - If product MSB is set, shift right 1 and increment e.
  - Keep MAN_W+1 bits. Guard = next lower bit. Sticky = OR of all remaining bits.
  - inexact = guard|sticky.
  - RNE: increment if guard & (sticky | lsb). RTZ: never increment.
  - A carry out of the rounding increment renormalises: shift right 1, e+1.
- Range checks, applied after rounding:
  - e ≥ EMAX_FIELD: overflow=1, inexact=1. Result is signed Inf for RNE, or signed max-finite {EMAX_FIELD−1, all-ones} for RTZ.
  - e ≤ 0: flush to signed zero (FTZ), underflow=1, inexact=1. Underflow is judged on the pre-rounding exponent.

## Timing
- Pipeline: S1 unpack/classify/mantissa multiply, S2 exponent add/normalise/guard-sticky, S3 round/range/pack. Output registers hold S3.
- Latency is 3 cycles from the in_valid&in_ready edge to out_valid. Throughput is 1 per cycle when out_ready is high.
- in_ready = !v1 | advance1, where each stage advances when it is empty or the stage after it advances. The output stage advances on out_ready.
- Bubbles collapse: an empty stage always accepts.
- A held result keeps product, out_tag and all flags stable until the out_valid&out_ready handshake completes. It is never dropped or duplicated.
- Simultaneous accept and emit in the same cycle is legal at full rate.
- Reset, asynchronous, active-low:
  - All stage valid bits clear.
  - out_valid, product, out_tag and all flags reset to 0.
  - in_ready goes to 1 in the first cycle after release.
- Reset asserted mid-operation discards all in-flight operations. Nothing is emitted after release until new input arrives.

## Structure
- Shared package fp_pkg holds:
  - the fp_class_e enum (ZERO, NORM, INF, QNAN, SNAN) and the rnd_mode_e enum
  - a flags struct {overflow, underflow, inexact, invalid}
  - function bias(EXP_W)
- One natural sub-module, fp_round_pack. It is combinational and performs rounding, range check and packing for stage 3. It is reusable by a later fp_add_pipe.
- Per-stage payload is kept in packed structs local to the module.

## Test plan
(bf16 defaults; RNE unless stated)
- 0x3FC0×0x3FC0 → 0x4010 (2.25), no flags, out_valid exactly 3 cycles after acceptance.
- Rounding, 0x3FC0×0x3F81:
  - RNE → 0x3FC2, inexact=1 (tie, round to even).
  - RTZ → 0x3FC1, inexact=1.
  - Separately, 0x3F81×0x3F81 → 0x3F82, inexact=1.
- Overflow, 0x7F00×0x4000:
  - RNE → 0x7F80, overflow=1, inexact=1.
  - RTZ → 0x7F7F, overflow=1, inexact=1.
- Underflow, 0x0080×0x3F00 → 0x0000, underflow=1, inexact=1. 0x8080×0x3F00 → 0x8000.
- Specials:
  - 0x0000×0x7F80 → 0x7FC0, invalid=1.
  - 0x7F81(sNaN)×0x3F80 → 0x7FC0, invalid=1.
  - 0x7FC1×0x3F80 → 0x7FC0, invalid=0.
  - 0xFF80×0x4000 → 0xFF80, no flags.
- Back-pressure: stream 6 ops with distinct tags, hold out_ready=0 for 5 cycles after the first result.
  - in_ready drops once 3 ops are held (S1–S3 full).
  - All 6 results emerge in order with correct tags.
  - Asserting reset mid-stream clears out_valid immediately, and nothing is emitted after release.
